cond_steer_stage: RTL
=====================

// Module: cond_steer_stage
// PURPOSE
// - Clocked, parametrised successor of the conditional-pass element in the data-driven pipeline.
// - Buffers incoming packets in a small FIFO.
// - Each packet carries a pass flag (exb) and a destination select.
// - Passing packets are steered to one of NUM_OUT output channels; failing packets are discarded and counted.
// - Sits between the firing/match stage and the fan-out to downstream channels.
// PARAMETERS
// - DATA_W     32  packet payload width.
// - NUM_OUT    2   number of output channels, >=1.
// - DEPTH      2   FIFO entries, >=1.
// - DISCARD_EN 1   1: exb=0 packets are dropped; 0: exb is ignored and every packet is steered.
// - CNT_W      16  width of drop_cnt.
// PORTS
// - cp         in   1            clock, rising edge.
// - MR         in   1            reset: synchronous, active-high.
// - in_valid   in   1            upstream packet valid.
// - in_ready   out  1            stage can accept (= !full).
// - in_data    in   DATA_W       payload.
// - in_sel     in   SEL_W        destination channel; SEL_W = max(1, clog2(NUM_OUT)).
// - in_exb     in   1            pass flag: 1 = forward, 0 = discard when DISCARD_EN=1.
// - out_valid  out  NUM_OUT      one-hot valid; at most one bit high.
// - out_ready  in   NUM_OUT      per-channel downstream ready.
// - out_data   out  DATA_W       shared payload bus; meaningful only where out_valid is high.
// - drop_cnt   out  CNT_W        packets discarded since reset; saturates at all-ones.
// - sel_err    out  1            sticky: set when a packet with in_sel >= NUM_OUT reaches the head.
// BEHAVIOUR
// - Reset (MR=1 at cp edge):
//   - FIFO count=0; out_valid=0; drop_cnt=0; sel_err=0; in_ready=1 from the next cycle.
//   - Reset overrides a push or pop in the same cycle; in-flight packets are lost and not counted.
// - Push: in_valid & in_ready at the edge stores {data, sel, exb}.
//   - Earliest out_valid is one cycle later; a packet never bypasses the FIFO.
// - in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
// - Head classification, combinational from head entry:
//   - DROP if DISCARD_EN & ~exb, or if sel >= NUM_OUT.
//   - Otherwise FWD to channel sel.
// - FWD: out_valid[sel]=1 and out_data=head data. Pop on out_ready[sel].
//   - out_ready of other channels is ignored.
//   - valid/data stay stable until accepted; valid is never withdrawn.
// - DROP: no out_valid. Head pops unconditionally in the same cycle.
//   - drop_cnt += 1, saturating.
//   - sel >= NUM_OUT also sets sel_err. sel_err clears only on MR.
// - Throughput: one pop per cycle, whether forwarded or dropped.
// - Simultaneous push and pop:
//   - Allowed whenever count < DEPTH; count is unchanged.
//   - When full, no push that cycle, since in_ready=0.
// - Empty FIFO: out_valid=0; out_data holds its last value (don't-care).
// - Pointers wrap modulo DEPTH. DEPTH need not be a power of two; use explicit wrap compare.
// - FIFO order is preserved across channels. A stalled head blocks all later packets (no reordering).
// STRUCTURE
// - Package cond_steer_pkg holds:
//   - function sel_w(n), returning max(1, $clog2(n));
//   - typedef/struct layout of the FIFO entry {exb, sel, data};
//   - localparam for the saturation value.
// - One sub-module, sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/head, sync active-high reset.
// - Steering, drop logic and counters live in cond_steer_stage.
// TESTING
// - Basic forward (NUM_OUT=2, DEPTH=2, out_ready=2'b11):
//   - Push {data=32'hA5, sel=1, exb=1}.
//   - Next cycle out_valid=2'b10, out_data=32'hA5; accepted same cycle; drop_cnt=0.
// - Discard:
//   - Push exb=0, sel=0; then exb=1, sel=0, data=7.
//   - First packet: no out_valid, drop_cnt=1.
//   - Following cycle: out_valid=2'b01, out_data=7.
// - Backpressure and full:
//   - out_ready=0; push 3 valid packets back-to-back.
//   - in_ready=0 after 2 accepted; third is held by upstream.
//   - Release out_ready[0]: packets exit in order, one per cycle.
// - Bad select (NUM_OUT=3):
//   - Push sel=3, exb=1 -> dropped; drop_cnt=1, sel_err=1 and stays 1 until MR.
// - Reset mid-operation:
//   - With FIFO full and out_valid high, assert MR for 1 cycle.
//   - Next cycle: out_valid=0, in_ready=1, drop_cnt=0, sel_err=0.
// - Saturation and mode (CNT_W=2, DISCARD_EN=1):
//   - Drop 5 packets -> drop_cnt=3.
//   - With DISCARD_EN=0, an exb=0 packet is forwarded normally.

Source files
------------

// File: rtl/cond_steer_pkg.sv
// Shared types and helpers for the conditional steering stage.
// The FIFO entry is laid out {exb, sel, data}, MSB first.
package cond_steer_pkg;

    // Width of a channel select, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int entry_w(input int data_w, input int sel_width);
        return 1 + sel_width + data_w;
    endfunction

    // Widest drop counter supported; narrower counters saturate at a truncated copy.
    localparam int MAX_CNT_W = 64;
    localparam logic [MAX_CNT_W-1:0] CNT_SAT_FULL = '1;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_FWD,
        HEAD_DROP
    } head_cls_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous active-high reset and a non-power-of-two depth.
// The head entry is presented combinationally from the read pointer.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cond_steer_stage.sv
// Buffers packets, then steers passing ones to a one-hot output channel and
// discards failing or misaddressed ones, counting every discard.
module cond_steer_stage
    import cond_steer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OUT    = 2,
    parameter int DEPTH      = 2,
    parameter int DISCARD_EN = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = sel_w(NUM_OUT)
) (
    input  logic               cp,
    input  logic               MR,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_exb,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               sel_err
);
    localparam int ENTRY_W = entry_w(DATA_W, SEL_W);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_SAT_FULL);
    localparam logic [SEL_W:0]   NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

    typedef struct packed {
        logic              exb;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t       wr_entry;
    entry_t       head;
    logic [ENTRY_W-1:0] head_bits;
    logic         fifo_full;
    logic         fifo_empty;
    logic         sel_bad;
    logic         fwd_ready;
    logic         pop;
    head_cls_e    cls;

    assign wr_entry = '{exb: in_exb, sel: in_sel, data: in_data};
    assign head     = entry_t'(head_bits);
    assign in_ready = ~fifo_full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (cp),
        .rst   (MR),
        .push  (in_valid),
        .pop   (pop),
        .wdata (wr_entry),
        .head  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Selects beyond the channel count can only be dropped, never forwarded.
    assign sel_bad = ({1'b0, head.sel} >= NUM_OUT_V);

    always_comb begin
        cls = HEAD_EMPTY;
        if (!fifo_empty) begin
            cls = (((DISCARD_EN != 0) && !head.exb) || sel_bad) ? HEAD_DROP : HEAD_FWD;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        out_valid = '0;
        fwd_ready = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (cls == HEAD_FWD && head.sel == SEL_W'(i)) begin
                out_valid[i] = 1'b1;
                fwd_ready    = out_ready[i];
            end
        end
    end

    // A dropped head leaves in the same cycle regardless of downstream readiness.
    assign pop      = (cls == HEAD_DROP) | fwd_ready;
    assign out_data = head.data;

    always_ff @(posedge cp) begin
        if (MR) begin
            drop_cnt <= '0;
            sel_err  <= 1'b0;
        end else if (cls == HEAD_DROP) begin
            if (drop_cnt != CNT_SAT) drop_cnt <= drop_cnt + 1'b1;
            if (sel_bad)             sel_err  <= 1'b1;
        end
    end

endmodule
